adder_ternary_gather: RTL
=========================

# adder_ternary_gather

Upstream feeder for `adder_ternary`. It accepts a serial valid/ready stream of `WIDTH`-bit words and groups consecutive words into operand triples. Each triple is presented on `out0`/`out1`/`out2` with a registered valid/ready handshake, so the ternary adder downstream sees three aligned operands per transfer. Short groups, terminated by `in_last`, are zero-padded so the downstream sum stays exact.

## Interface
- `WIDTH`, 8, data width of input words and of each output operand (≥1)
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  input word valid
- `in_ready`  out  1  input word accepted when `in_valid & in_ready` at a rising edge
- `in_data`  in  `WIDTH`  input word
- `in_last`  in  1  current word ends the group (see Configuration)
- `out_valid`  out  1  triple valid
- `out_ready`  in  1  downstream accepts the triple when `out_valid & out_ready`
- `out0`  out  `WIDTH`  first word of the group
- `out1`  out  `WIDTH`  second word, or 0 if the group is shorter
- `out2`  out  `WIDTH`  third word, or 0 if the group is shorter
- `out_count`  out  2  number of real words in the triple (1..3)

## Operation
- Internal state:
  - collection index `idx` ∈ {0,1,2}
  - slot registers `s0`, `s1`
  - output register set {`out0..2`, `out_count`, `out_valid`}
- FSM on `idx`:
  - IDLE (0): an accepted word goes to `s0`; `idx` becomes 1.
  - ONE (1): an accepted word goes to `s1`; `idx` becomes 2.
  - TWO (2): the next accepted word completes the group.
- Group completion happens when a word is accepted in TWO, or a word with `in_last=1` is accepted in any state.
  - The output register loads {`s0`, `s1`, `in_data`}, with positions shifted so words fill `out0` first and unused positions are 0.
  - `out_count` loads 1, 2 or 3.
  - `out_valid` is set to 1 and `idx` returns to 0.
- Example fills: `in_last` in IDLE gives {d,0,0}, count 1. `in_last` in ONE gives {s0,d,0}, count 2.
- `in_ready = !out_valid | out_ready`. It is combinational from `out_valid`/`out_ready` only, never from `in_valid` or `in_last`.
- Output handshake:
  - `out_valid` clears on `out_valid & out_ready` unless a group completes on the same edge.
  - If a group completes on that same edge, the register reloads and `out_valid` stays 1.
- While `out_valid=1 & out_ready=0`, outputs hold stable and no input is accepted.
- `in_valid=0` leaves all state unchanged; partial groups wait indefinitely.
- Reset mid-group discards the partial group and any pending triple.

## Timing
- Reset values: `out_valid`=0, `out0`=`out1`=`out2`=0, `out_count`=0, `idx`=0, `s0`=`s1`=0.
- `in_ready`=1 while in reset.
- Latency: completing word accepted at edge N gives `out_valid`=1 with the triple after edge N.
- Throughput: one input word per cycle sustained with `out_ready`=1. One triple per 3 cycles for full groups; one per cycle for groups of length 1.
- No bubble on back-to-back groups when `out_ready`=1.

## Configuration
- Macro: `ADDER_TERNARY_GATHER_LAST_EN`.
- Defined: `in_last` is honoured as described above, producing variable-length groups of 1..3 words with zero padding.
- Undefined:
  - `in_last` is ignored; the port stays present and is left unused.
  - Every group is exactly 3 words and `out_count` is always 3 when `out_valid`=1.
  - Padding logic is removed.

## Test plan
- Reset then idle:
  - During and after async `rst` assertion mid-cycle, `out_valid`=0, outputs 0, `in_ready`=1.
- Stream 0x01..0x06, `out_ready`=1:
  - Triples {01,02,03} then {04,05,06}, `out_count`=3.
  - Each triple appears one cycle after its third word.
- With LAST_EN defined:
  - 0x0A with `in_last` gives {0A,00,00}, count 2'd1.
  - Then 0x0B, then 0x0C with `in_last`, gives {0B,0C,00}, count 2'd2.
- Backpressure: hold `out_ready`=0 with triple {07,08,09} pending and feed 0x10.
  - `in_ready`=0 and outputs stable for 5 cycles.
  - Release: the triple transfers; 0x10 is accepted on the release edge.
- Simultaneous events:
  - With triple pending and `out_ready`=1, the completing word of the next group is accepted on the same edge.
  - `out_valid` stays 1 and the new triple appears with no gap.
- Reset mid-group:
  - After 2 words, assert `rst`; then send 0x21,0x22,0x23.
  - Output is {21,22,23}; no stale data.

Source files
------------

// File: rtl/adder_ternary_gather.sv
// Groups a serial valid/ready word stream into aligned operand triples for adder_ternary.
// Define ADDER_TERNARY_GATHER_LAST_EN to honour in_last (short groups, zero padded).
module adder_ternary_gather #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [1:0]       out_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] s0, s1;
  logic [WIDTH-1:0] ld0, ld1, ld2;
  logic [1:0]       ld_cnt;
  logic             accept, grp_done, last_w;

  // The output register is a one-deep skid: it can reload on the same edge it drains.
  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

`ifdef ADDER_TERNARY_GATHER_LAST_EN
  assign last_w = in_last;
`else
  logic unused_last;
  assign unused_last = in_last;
  assign last_w      = 1'b0;
`endif

  assign grp_done = accept & ((state == TWO) | last_w);

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        IDLE:    state_nxt = ONE;
        ONE:     state_nxt = TWO;
        default: state_nxt = IDLE;
      endcase
      if (grp_done) state_nxt = IDLE;
    end
  end

  // Words fill out0 first; positions past the group length read as zero.
  always_comb begin
    ld0    = s0;
    ld1    = s1;
    ld2    = in_data;
    ld_cnt = 2'd3;
`ifdef ADDER_TERNARY_GATHER_LAST_EN
    case (state)
      IDLE: begin
        ld0    = in_data;
        ld1    = '0;
        ld2    = '0;
        ld_cnt = 2'd1;
      end
      ONE: begin
        ld1    = in_data;
        ld2    = '0;
        ld_cnt = 2'd2;
      end
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s0    <= '0;
      s1    <= '0;
    end else begin
      state <= state_nxt;
      if (accept && state == IDLE) s0 <= in_data;
      if (accept && state == ONE)  s1 <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out0      <= '0;
      out1      <= '0;
      out2      <= '0;
      out_count <= 2'd0;
    end else if (grp_done) begin
      out_valid <= 1'b1;
      out0      <= ld0;
      out1      <= ld1;
      out2      <= ld2;
      out_count <= ld_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
